// File: rtl/wb_ram_arbiter.sv
// wb_ram_arbiter: two-master Wishbone classic arbiter sharing one RAM slave
// between the instruction-fetch bus (ibus) and the data bus (dbus).
// The grant is registered, so a request from IDLE reaches the slave one cycle later.
// A watchdog ends any granted strobe that the slave leaves unacknowledged.
// Build option: define WB_ARB_ROUND_ROBIN_EN to break ties in favour of the
// master that did not own the bus last. Without it, dbus has fixed priority.
module wb_ram_arbiter #(
    parameter int TIMEOUT = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] ibus_addr,
    input  logic [31:0] ibus_wdata,
    input  logic [3:0]  ibus_sel,
    input  logic        ibus_we,
    input  logic        ibus_cyc,
    input  logic        ibus_stb,
    output logic [31:0] ibus_rdata,
    output logic        ibus_ack,
    output logic        ibus_err,
    input  logic [31:0] dbus_addr,
    input  logic [31:0] dbus_wdata,
    input  logic [3:0]  dbus_sel,
    input  logic        dbus_we,
    input  logic        dbus_cyc,
    input  logic        dbus_stb,
    output logic [31:0] dbus_rdata,
    output logic        dbus_ack,
    output logic        dbus_err,
    output logic [31:0] ram_addr,
    output logic [31:0] ram_wdata,
    output logic [3:0]  ram_sel,
    output logic        ram_we,
    output logic        ram_cyc,
    output logic        ram_stb,
    input  logic [31:0] ram_rdata,
    input  logic        ram_ack
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_GNT_I = 2'd1;
    localparam logic [1:0] S_GNT_D = 2'd2;

    // Final count value: the strobe cycle that sees this count with no ack
    // is the last one. The following cycle is the error cycle.
    localparam logic [7:0] WDT_LAST = 8'(TIMEOUT - 1);

    logic [1:0] r_state;
    logic [1:0] w_next;
    logic [7:0] r_wdt;
    logic       r_err;      // high during the error-termination cycle
    logic       w_req_i;
    logic       w_req_d;
    logic       w_own_i;
    logic       w_own_d;
    logic       w_cyc;
    logic       w_stb;
    logic       w_hit;
    logic       w_pick_d;   // tie-break result from IDLE: 1 = dbus

    assign w_req_i = ibus_cyc & ibus_stb;
    assign w_req_d = dbus_cyc & dbus_stb;
    assign w_own_i = (r_state == S_GNT_I);
    assign w_own_d = (r_state == S_GNT_D);

    // The error cycle keeps the grant so that err reaches the right master.
    // The slave must not see a live strobe in that cycle.
    assign w_cyc = ~r_err & ((w_own_i & ibus_cyc) | (w_own_d & dbus_cyc));
    assign w_stb = ~r_err & ((w_own_i & ibus_stb) | (w_own_d & dbus_stb));
    assign w_hit = w_stb & ~ram_ack & (r_wdt == WDT_LAST);

`ifdef WB_ARB_ROUND_ROBIN_EN
    logic r_last;           // most recent owner: 0 = ibus, 1 = dbus

    assign w_pick_d = ~r_last;

    // Track the latest grant for the round-robin tie-break
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            r_last <= 1'b0;
        else if (w_next != S_IDLE)
            r_last <= (w_next == S_GNT_D);
    end
`else
    assign w_pick_d = 1'b1;
`endif

    // Grant selection: rearbitrate on ack, or when the owner drops cyc
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_req_i && w_req_d)
                    w_next = w_pick_d ? S_GNT_D : S_GNT_I;
                else if (w_req_d)
                    w_next = S_GNT_D;
                else if (w_req_i)
                    w_next = S_GNT_I;
            end
            S_GNT_I: begin
                if (r_err)
                    w_next = S_IDLE;
                else if (w_hit)
                    w_next = S_GNT_I;
                else if (ram_ack)
                    w_next = w_req_d ? S_GNT_D : (ibus_cyc ? S_GNT_I : S_IDLE);
                else if (!ibus_cyc)
                    w_next = w_req_d ? S_GNT_D : S_IDLE;
            end
            S_GNT_D: begin
                if (r_err)
                    w_next = S_IDLE;
                else if (w_hit)
                    w_next = S_GNT_D;
                else if (ram_ack) begin
`ifdef WB_ARB_ROUND_ROBIN_EN
                    w_next = w_req_i ? S_GNT_I : (dbus_cyc ? S_GNT_D : S_IDLE);
`else
                    if (w_req_d)
                        w_next = S_GNT_D;
                    else if (w_req_i)
                        w_next = S_GNT_I;
                    else
                        w_next = dbus_cyc ? S_GNT_D : S_IDLE;
`endif
                end
                else if (!dbus_cyc)
                    w_next = w_req_i ? S_GNT_I : S_IDLE;
            end
            default: w_next = S_IDLE;
        endcase
    end

    // Grant state, error flag and watchdog count
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= S_IDLE;
            r_err   <= 1'b0;
            r_wdt   <= 8'd0;
        end else begin
            r_state <= w_next;
            r_err   <= w_hit;
            if (r_err || w_hit || ram_ack || (w_next != r_state))
                r_wdt <= 8'd0;
            else if (w_stb)
                r_wdt <= r_wdt + 8'd1;
        end
    end

    assign ram_addr   = w_own_i ? ibus_addr  : (w_own_d ? dbus_addr  : 32'd0);
    assign ram_wdata  = w_own_i ? ibus_wdata : (w_own_d ? dbus_wdata : 32'd0);
    assign ram_sel    = w_own_i ? ibus_sel   : (w_own_d ? dbus_sel   : 4'd0);
    assign ram_we     = w_own_i ? ibus_we    : (w_own_d ? dbus_we    : 1'b0);
    assign ram_cyc    = w_cyc;
    assign ram_stb    = w_stb;

    assign ibus_ack   = w_own_i & ram_ack & ~r_err;
    assign dbus_ack   = w_own_d & ram_ack & ~r_err;
    assign ibus_err   = w_own_i & r_err;
    assign dbus_err   = w_own_d & r_err;
    assign ibus_rdata = w_own_i ? ram_rdata : 32'd0;
    assign dbus_rdata = w_own_d ? ram_rdata : 32'd0;

endmodule

// File: tb/tb_wb_ram_arbiter.sv
// Directed bench for wb_ram_arbiter. The slave model acks one cycle after a strobe
// and idles for one cycle between acks. An injection input forces stray acks.
module tb_wb_ram_arbiter;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] ibus_addr = '0, ibus_wdata = '0, dbus_addr = '0, dbus_wdata = '0;
    logic [3:0]  ibus_sel = '0, dbus_sel = '0;
    logic        ibus_we = 0, ibus_cyc = 0, ibus_stb = 0;
    logic        dbus_we = 0, dbus_cyc = 0, dbus_stb = 0;
    logic [31:0] ibus_rdata, dbus_rdata, ram_addr, ram_wdata;
    logic        ibus_ack, dbus_ack, ibus_err, dbus_err;
    logic [3:0]  ram_sel;
    logic        ram_we, ram_cyc, ram_stb;
    logic [31:0] slv_rdata = '0;
    logic        slv_en = 1'b1;
    logic        inj_ack = 1'b0;
    logic        r_sack = 1'b0;
    logic        ram_ack;

    int n_pass = 0;
    int n_total = 0;

    wb_ram_arbiter #(.TIMEOUT(16)) dut (
        .clk(clk), .reset(rst_n),
        .ibus_addr(ibus_addr), .ibus_wdata(ibus_wdata), .ibus_sel(ibus_sel),
        .ibus_we(ibus_we), .ibus_cyc(ibus_cyc), .ibus_stb(ibus_stb),
        .ibus_rdata(ibus_rdata), .ibus_ack(ibus_ack), .ibus_err(ibus_err),
        .dbus_addr(dbus_addr), .dbus_wdata(dbus_wdata), .dbus_sel(dbus_sel),
        .dbus_we(dbus_we), .dbus_cyc(dbus_cyc), .dbus_stb(dbus_stb),
        .dbus_rdata(dbus_rdata), .dbus_ack(dbus_ack), .dbus_err(dbus_err),
        .ram_addr(ram_addr), .ram_wdata(ram_wdata), .ram_sel(ram_sel),
        .ram_we(ram_we), .ram_cyc(ram_cyc), .ram_stb(ram_stb),
        .ram_rdata(slv_rdata), .ram_ack(ram_ack)
    );

    wire [138:0] all_outs = {ibus_rdata, dbus_rdata, ibus_ack, dbus_ack, ibus_err, dbus_err,
                             ram_addr, ram_wdata, ram_sel, ram_we, ram_cyc, ram_stb};

    always #5 clk = ~clk;

    // Registered slave: ack one cycle after a strobe, never on two cycles in a row
    always @(posedge clk) r_sack <= slv_en & ram_cyc & ram_stb & ~r_sack;
    assign ram_ack = r_sack | inj_ack;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_masters();
        ibus_cyc = 0; ibus_stb = 0; ibus_we = 0; ibus_addr = '0; ibus_wdata = '0; ibus_sel = '0;
        dbus_cyc = 0; dbus_stb = 0; dbus_we = 0; dbus_addr = '0; dbus_wdata = '0; dbus_sel = '0;
    endtask

    task automatic settle();
        idle_masters();
        inj_ack = 0;
        slv_en = 1;
        repeat (3) tick();
    endtask

    task automatic test_reset();
        rst_n = 0;
        for (int k = 0; k < 5; k++) begin
            ibus_addr = $urandom; ibus_wdata = $urandom; ibus_sel = 4'($urandom);
            ibus_we = 1'($urandom_range(0, 1)); ibus_cyc = 1'($urandom_range(0, 1));
            ibus_stb = 1'($urandom_range(0, 1));
            dbus_addr = $urandom; dbus_wdata = $urandom; dbus_sel = 4'($urandom);
            dbus_we = 1'($urandom_range(0, 1)); dbus_cyc = 1; dbus_stb = 1;
            inj_ack = 1'($urandom_range(0, 1));
            slv_rdata = $urandom;
            @(negedge clk);
            n_total++; if (all_outs !== '0) $display("FAIL reset_outs: got %h want 0", all_outs); else n_pass++;
            tick();
        end
        idle_masters();
        inj_ack = 0;
        tick();
        rst_n = 1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            n_total++; if (ram_cyc !== 1'b0) $display("FAIL idle_ram_cyc: got %b want 0", ram_cyc); else n_pass++;
            tick();
        end
    endtask

    task automatic test_ibus_read();
        slv_rdata = 32'hDEADBEEF;
        ibus_addr = 32'h100; ibus_sel = 4'hF; ibus_we = 0; ibus_cyc = 1; ibus_stb = 1;
        @(negedge clk);
        n_total++; if (ram_stb !== 1'b0) $display("FAIL rd_c0_stb: got %b want 0", ram_stb); else n_pass++;
        tick(); @(negedge clk);
        n_total++; if (ram_stb !== 1'b1) $display("FAIL rd_c1_stb: got %b want 1", ram_stb); else n_pass++;
        n_total++; if (ram_addr !== 32'h100) $display("FAIL rd_c1_addr: got %h want 100", ram_addr); else n_pass++;
        n_total++; if (ibus_ack !== 1'b0) $display("FAIL rd_c1_ack: got %b want 0", ibus_ack); else n_pass++;
        tick(); @(negedge clk);
        n_total++; if (ibus_ack !== 1'b1) $display("FAIL rd_c2_iack: got %b want 1", ibus_ack); else n_pass++;
        n_total++; if (ibus_rdata !== 32'hDEADBEEF) $display("FAIL rd_c2_irdata: got %h want deadbeef", ibus_rdata); else n_pass++;
        n_total++; if (dbus_ack !== 1'b0) $display("FAIL rd_c2_dack: got %b want 0", dbus_ack); else n_pass++;
        n_total++; if (dbus_rdata !== 32'h0) $display("FAIL rd_c2_drdata: got %h want 0", dbus_rdata); else n_pass++;
        settle();
    endtask

    task automatic test_tie();
        slv_rdata = 32'h0BADF00D;
        dbus_addr = 32'h200; dbus_wdata = 32'h55; dbus_sel = 4'b0001; dbus_we = 1; dbus_cyc = 1; dbus_stb = 1;
        ibus_addr = 32'h300; ibus_sel = 4'hF; ibus_we = 0; ibus_cyc = 1; ibus_stb = 1;
        tick(); @(negedge clk);
        n_total++; if (ram_addr !== 32'h200) $display("FAIL tie_addr: got %h want 200", ram_addr); else n_pass++;
        n_total++; if (ram_we !== 1'b1) $display("FAIL tie_we: got %b want 1", ram_we); else n_pass++;
        n_total++; if (ram_sel !== 4'b0001) $display("FAIL tie_sel: got %b want 0001", ram_sel); else n_pass++;
        n_total++; if (ram_wdata !== 32'h55) $display("FAIL tie_wdata: got %h want 55", ram_wdata); else n_pass++;
        tick(); @(negedge clk);
        n_total++; if ({dbus_ack, ibus_ack} !== 2'b10) $display("FAIL tie_d_ack: got d/i %b want 10", {dbus_ack, ibus_ack}); else n_pass++;
        // dbus is satisfied and withdraws in its ack cycle
        dbus_cyc = 0; dbus_stb = 0; dbus_we = 0;
        tick(); @(negedge clk);
        n_total++; if ({ram_stb, ram_addr} !== {1'b1, 32'h300}) $display("FAIL tie_handover: got stb/addr %b/%h want 1/300", ram_stb, ram_addr); else n_pass++;
        n_total++; if (ram_we !== 1'b0) $display("FAIL tie_i_we: got %b want 0", ram_we); else n_pass++;
        tick(); @(negedge clk);
        n_total++; if ({dbus_ack, ibus_ack} !== 2'b01) $display("FAIL tie_i_ack: got d/i %b want 01", {dbus_ack, ibus_ack}); else n_pass++;
        settle();
    endtask

    task automatic test_back_to_back();
        logic [5:0] acks;
        acks = '0;
        ibus_addr = 32'h140; ibus_sel = 4'hF; ibus_cyc = 1; ibus_stb = 1;
        for (int n = 1; n <= 6; n++) begin
            tick(); @(negedge clk);
            acks[n-1] = ibus_ack;
        end
        n_total++; if (acks !== 6'b101010) $display("FAIL b2b_cadence: got %b want 101010", acks); else n_pass++;
        settle();
    endtask

    task automatic test_drop_handover();
        slv_en = 0;
        dbus_addr = 32'h280; dbus_cyc = 1; dbus_stb = 1;
        tick(); @(negedge clk);
        // dbus abandons its unacked cycle as ibus asks; ibus is granted without IDLE
        dbus_cyc = 0; dbus_stb = 0;
        ibus_addr = 32'h700; ibus_cyc = 1; ibus_stb = 1;
        tick();
        slv_en = 1;
        @(negedge clk);
        n_total++; if ({ram_stb, ram_addr} !== {1'b1, 32'h700}) $display("FAIL drop_direct: got stb/addr %b/%h want 1/700", ram_stb, ram_addr); else n_pass++;
        tick(); @(negedge clk);
        n_total++; if (ibus_ack !== 1'b1) $display("FAIL drop_i_ack: got %b want 1", ibus_ack); else n_pass++;
        settle();
    endtask

    task automatic test_contention();
        logic [7:0] seq, exp;
        int         n_ack;
        logic       both;
`ifdef WB_ARB_ROUND_ROBIN_EN
        exp = 8'b01010101;
`else
        exp = 8'hFF;
`endif
        rst_n = 0; tick(); rst_n = 1; tick();
        seq = '0; n_ack = 0; both = 0;
        dbus_addr = 32'h800; dbus_cyc = 1; dbus_stb = 1;
        ibus_addr = 32'h900; ibus_cyc = 1; ibus_stb = 1;
        for (int c = 0; c < 40 && n_ack < 8; c++) begin
            @(negedge clk);
            if (ibus_ack && dbus_ack) both = 1;
            if (ibus_ack || dbus_ack) begin
                seq[n_ack[2:0]] = dbus_ack;
                n_ack++;
            end
            tick();
        end
        n_total++; if (n_ack != 8) $display("FAIL cont_count: got %0d want 8", n_ack); else n_pass++;
        n_total++; if (seq !== exp) $display("FAIL cont_order: got %b want %b (bit0 first, 1=dbus)", seq, exp); else n_pass++;
        n_total++; if (both !== 1'b0) $display("FAIL cont_dual_ack: got %b want 0", both); else n_pass++;
        settle();
    endtask

    task automatic test_timeout();
        int   err_at;
        logic stb_at, cyc_at, ierr_at;
        err_at = 0; stb_at = 1; cyc_at = 1; ierr_at = 1;
        slv_en = 0;
        dbus_addr = 32'h400; dbus_cyc = 1; dbus_stb = 1;
        tick();
        for (int n = 1; n <= 40; n++) begin
            @(negedge clk);
            if (n == 1) begin
                n_total++; if (ram_stb !== 1'b1) $display("FAIL wdt_first_stb: got %b want 1", ram_stb); else n_pass++;
            end
            if (dbus_err) begin
                err_at = n; stb_at = ram_stb; cyc_at = ram_cyc; ierr_at = ibus_err;
                break;
            end
            tick();
        end
        n_total++; if (err_at != 17) $display("FAIL wdt_err_cycle: got %0d want 17", err_at); else n_pass++;
        n_total++; if ({stb_at, cyc_at} !== 2'b00) $display("FAIL wdt_err_gate: got stb/cyc %b%b want 00", stb_at, cyc_at); else n_pass++;
        n_total++; if (ierr_at !== 1'b0) $display("FAIL wdt_ierr: got %b want 0", ierr_at); else n_pass++;
        // A late ack landing in the error cycle must reach nobody
        inj_ack = 1; #1;
        n_total++; if ({dbus_ack, ibus_ack} !== 2'b00) $display("FAIL wdt_err_ack: got d/i %b want 00", {dbus_ack, ibus_ack}); else n_pass++;
        inj_ack = 0;
        idle_masters();
        tick(); @(negedge clk);
        n_total++; if ({dbus_err, ram_cyc} !== 2'b00) $display("FAIL wdt_after: got err/cyc %b%b want 00", dbus_err, ram_cyc); else n_pass++;
        settle();
    endtask

    task automatic test_reset_mid();
        slv_rdata = 32'h12345678;
        ibus_addr = 32'h500; ibus_sel = 4'hF; ibus_cyc = 1; ibus_stb = 1;
        tick(); @(negedge clk);
        n_total++; if (ram_stb !== 1'b1) $display("FAIL rst_mid_stb: got %b want 1", ram_stb); else n_pass++;
        tick();
        rst_n = 0; #1;
        n_total++; if (all_outs !== '0) $display("FAIL rst_mid_outs: got %h want 0", all_outs); else n_pass++;
        idle_masters();
        tick();
        rst_n = 1;
        inj_ack = 1; #1;
        n_total++; if ({ibus_ack, dbus_ack} !== 2'b00) $display("FAIL rst_late_ack: got i/d %b want 00", {ibus_ack, dbus_ack}); else n_pass++;
        @(negedge clk);
        inj_ack = 0;
        tick();
        slv_rdata = 32'hCAFEF00D;
        ibus_addr = 32'h600; ibus_cyc = 1; ibus_stb = 1;
        tick(); @(negedge clk);
        n_total++; if ({ram_stb, ram_addr} !== {1'b1, 32'h600}) $display("FAIL rst_next_req: got stb/addr %b/%h want 1/600", ram_stb, ram_addr); else n_pass++;
        tick(); @(negedge clk);
        n_total++; if ({ibus_ack, ibus_rdata} !== {1'b1, 32'hCAFEF00D}) $display("FAIL rst_next_ack: got ack/rdata %b/%h want 1/cafef00d", ibus_ack, ibus_rdata); else n_pass++;
        settle();
    endtask

    initial begin
        test_reset();
        test_ibus_read();
        test_tie();
        test_back_to_back();
        test_drop_handover();
        test_contention();
        test_timeout();
        test_reset_mid();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL sim_timeout: got no finish want finish by 200000");
        $fatal(1);
    end

endmodule
